// File: rtl/pmp_scan_checker.sv
// Sequential PMP permission checker: scans one PMP entry per cycle in priority
// order, stops at the first match and returns allow/fault over a valid/ready channel.
module pmp_scan_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int PMP_NUM    = 16,
    parameter int IDX_W      = $clog2(PMP_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_vld,
    output logic                          req_rdy,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [1:0]                    req_type,
    input  logic [1:0]                    req_priv,
    input  logic [PMP_NUM*8-1:0]          pmp_cfg,
    input  logic [PMP_NUM*ADDR_WIDTH-1:0] pmp_addr,
    output logic                          resp_vld,
    input  logic                          resp_rdy,
    output logic                          resp_fault,
    output logic                          resp_hit,
    output logic [IDX_W-1:0]              resp_idx
);

    localparam logic [1:0]       A_TOR     = 2'b01;
    localparam logic [1:0]       A_NA4     = 2'b10;
    localparam logic [1:0]       A_NAPOT   = 2'b11;
    localparam logic [1:0]       PRIV_M    = 2'b11;
    localparam logic [1:0]       TYPE_RSVD = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PMP_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            type_q;
    logic [1:0]            priv_q;
    logic [IDX_W-1:0]      idx;

    logic [7:0]            cfg_arr [PMP_NUM];
    logic [ADDR_WIDTH-1:0] pa_arr  [PMP_NUM];

    always_comb begin
        for (int i = 0; i < PMP_NUM; i++) begin
            cfg_arr[i] = pmp_cfg[i*8 +: 8];
            pa_arr[i]  = pmp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    logic [7:0]            cur_cfg;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic [ADDR_WIDTH-1:0] napot_mask;
    logic                  entry_hit;
    logic                  perm_ok;
    logic                  is_m;
    logic                  hit_fault;
    logic                  miss_fault;
    logic                  cfg_rsvd_unused;

    // Single shared match datapath, steered by the scan index.
    always_comb begin
        cur_cfg         = cfg_arr[idx];
        cur_addr        = pa_arr[idx];
        prev_addr       = (idx == '0) ? '0 : pa_arr[idx - IDX_W'(1)];
        napot_mask      = cur_addr ^ (cur_addr + ADDR_WIDTH'(1));
        cfg_rsvd_unused = ^cur_cfg[6:5];

        entry_hit = 1'b0;
        case (cur_cfg[4:3])
            A_TOR:   entry_hit = (addr_q >= prev_addr) && (addr_q < cur_addr);
            A_NA4:   entry_hit = (addr_q == cur_addr);
            A_NAPOT: entry_hit = ((addr_q & ~napot_mask) == (cur_addr & ~napot_mask));
            default: entry_hit = 1'b0;
        endcase

        perm_ok = 1'b0;
        case (type_q)
            2'b00:   perm_ok = cur_cfg[0];
            2'b01:   perm_ok = cur_cfg[1];
            2'b10:   perm_ok = cur_cfg[2];
            default: perm_ok = 1'b0;
        endcase

        // Priv encoding 10 is not M, so it falls through to the U/S rules.
        is_m       = (priv_q == PRIV_M);
        hit_fault  = (type_q == TYPE_RSVD) || !((is_m && !cur_cfg[7]) || perm_ok);
        miss_fault = (type_q == TYPE_RSVD) || !is_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            addr_q     <= '0;
            type_q     <= '0;
            priv_q     <= '0;
            resp_fault <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld && req_rdy) begin
                        addr_q <= req_addr;
                        type_q <= req_type;
                        priv_q <= req_priv;
                        idx    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (entry_hit) begin
                        resp_hit   <= 1'b1;
                        resp_idx   <= idx;
                        resp_fault <= hit_fault;
                        state      <= RESP;
                    end else if (idx == LAST_IDX) begin
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                        resp_fault <= miss_fault;
                        state      <= RESP;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_rdy  = (state == IDLE) && !rst;
    assign resp_vld = (state == RESP);

endmodule

// File: tb/tb_pmp_scan_checker.sv
// Scoreboard bench for pmp_scan_checker: directed and random accesses checked
// against a range-based PMP reference model, with randomized response backpressure.
module tb_pmp_scan_checker;

    localparam int AW = 32;
    localparam int N  = 16;
    localparam int IW = 4;

    logic              clk;
    logic              rst;
    logic              req_vld;
    logic              req_rdy;
    logic [AW-1:0]     req_addr;
    logic [1:0]        req_type;
    logic [1:0]        req_priv;
    logic [N*8-1:0]    pmp_cfg;
    logic [N*AW-1:0]   pmp_addr;
    logic              resp_vld;
    logic              resp_rdy;
    logic              resp_fault;
    logic              resp_hit;
    logic [IW-1:0]     resp_idx;

    logic [7:0]        cfg_arr [N];
    logic [AW-1:0]     pa_arr  [N];

    typedef struct {
        logic   fault;
        logic   hit;
        int     idx;
        int     lat;
        longint accept_cyc;
    } exp_t;

    exp_t   sb_q [$];
    int     check_cnt = 0;
    int     pass_cnt  = 0;
    longint cyc       = 0;
    bit     bp_hold   = 0;
    bit     bp_rand   = 0;

    pmp_scan_checker #(.ADDR_WIDTH(AW), .PMP_NUM(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .req_priv   (req_priv),
        .pmp_cfg    (pmp_cfg),
        .pmp_addr   (pmp_addr),
        .resp_vld   (resp_vld),
        .resp_rdy   (resp_rdy),
        .resp_fault (resp_fault),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pmp_cfg[i*8 +: 8]   = cfg_arr[i];
            pmp_addr[i*AW +: AW] = pa_arr[i];
        end
    end

    // Response backpressure changes just after the rising edge.
    initial begin
        resp_rdy = 1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold)      resp_rdy = 0;
            else if (bp_rand) resp_rdy = ($urandom_range(0, 3) != 0);
            else              resp_rdy = 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] cfgByte(input bit r, input bit w, input bit x,
                                           input logic [1:0] a, input bit l);
        return {l, 2'b00, a, x, w, r};
    endfunction

    task automatic clearCfg();
        for (int i = 0; i < N; i++) begin
            cfg_arr[i] = 8'h00;
            pa_arr[i]  = '0;
        end
    endtask

    // Reference: each entry is turned into an explicit [lo, hi) word range.
    function automatic exp_t refModel(input logic [AW-1:0] a, input logic [1:0] t,
                                      input logic [1:0] p);
        exp_t        e;
        logic [63:0] lo, hi, a64;
        int          tz;
        bit          match;
        e.hit = 0; e.idx = 0; e.fault = 0; e.lat = N; e.accept_cyc = 0;
        a64 = {32'b0, a};
        for (int i = 0; i < N; i++) begin
            lo = 0; hi = 0;
            case (cfg_arr[i][4:3])
                2'd1: begin
                    lo = (i == 0) ? 64'd0 : {32'b0, pa_arr[i-1]};
                    hi = {32'b0, pa_arr[i]};
                end
                2'd2: begin
                    lo = {32'b0, pa_arr[i]};
                    hi = lo + 1;
                end
                2'd3: begin
                    tz = 0;
                    while (tz < AW && pa_arr[i][tz]) tz++;
                    hi = 64'd1 << (tz + 1);
                    lo = {32'b0, pa_arr[i]} & ~(hi - 1);
                    hi = lo + hi;
                end
                default: ;
            endcase
            match = (a64 >= lo) && (a64 < hi);
            if (match) begin
                e.hit = 1; e.idx = i; e.lat = i + 1;
                break;
            end
        end
        if (t == 2'b11)  e.fault = 1;
        else if (e.hit)  e.fault = !((p == 2'b11 && !cfg_arr[e.idx][7]) || cfg_arr[e.idx][t]);
        else             e.fault = (p != 2'b11);
        return e;
    endfunction

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [1:0] t,
                                 input logic [1:0] p, input bit track);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_addr = a; req_type = t; req_priv = p; req_vld = 1;
        while (!req_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_accept", req_rdy, 1);
        if (req_rdy) begin
            @(posedge clk);
            #1;
            if (track) begin
                e = refModel(a, t, p);
                e.accept_cyc = cyc;
                sb_q.push_back(e);
            end
        end
        req_vld  = 0;
        req_addr = $urandom;
        req_type = 2'($urandom);
        req_priv = 2'($urandom);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(sb_q.size()), 0);
    endtask

    // Monitor: pops the scoreboard at each response handshake.
    initial begin
        bit         seen;
        longint     rise;
        logic       f, h;
        logic [IW-1:0] ix;
        exp_t       e;
        seen = 0; rise = 0; f = 0; h = 0; ix = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else if (resp_vld) begin
                checkOutput("req_rdy_low_in_resp", req_rdy, 0);
                if (!seen) begin
                    seen = 1; rise = cyc;
                    f = resp_fault; h = resp_hit; ix = resp_idx;
                end else begin
                    checkOutput("fault_stable", resp_fault, f);
                    checkOutput("hit_stable", resp_hit, h);
                    checkOutput("idx_stable", resp_idx, ix);
                end
                if (resp_rdy) begin
                    checkOutput("resp_expected", 64'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        checkOutput("resp_hit", resp_hit, e.hit);
                        checkOutput("resp_idx", resp_idx, 64'(e.idx));
                        checkOutput("resp_fault", resp_fault, e.fault);
                        checkOutput("latency", 64'(rise - e.accept_cyc), 64'(e.lat));
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1; req_vld = 0; req_addr = 0; req_type = 0; req_priv = 0;
        clearCfg();
        repeat (2) @(negedge clk);
        checkOutput("rst_req_rdy", req_rdy, 0);
        checkOutput("rst_resp_vld", resp_vld, 0);
        checkOutput("rst_resp_fault", resp_fault, 0);
        checkOutput("rst_resp_hit", resp_hit, 0);
        checkOutput("rst_resp_idx", resp_idx, 0);
        rst = 0;
        #1;
        checkOutput("rdy_after_rst", req_rdy, 1);

        // TOR entry 0, hit and miss-at-boundary
        pa_arr[0] = 32'h100; cfg_arr[0] = cfgByte(1, 0, 0, 2'd1, 0);
        applyStimulus(32'h0FF, 2'b00, 2'b00, 1);
        applyStimulus(32'h100, 2'b00, 2'b00, 1);
        waitDrain();

        // NAPOT entry 3 covering 0x1000..0x1007
        clearCfg();
        pa_arr[3] = 32'h1003; cfg_arr[3] = cfgByte(1, 0, 1, 2'd3, 0);
        applyStimulus(32'h1005, 2'b01, 2'b01, 1);
        applyStimulus(32'h1005, 2'b10, 2'b01, 1);
        applyStimulus(32'h1008, 2'b10, 2'b01, 1);
        waitDrain();

        // Priority between overlapping entries 2 and 5
        clearCfg();
        pa_arr[2] = 32'h40; cfg_arr[2] = cfgByte(0, 0, 0, 2'd2, 0);
        pa_arr[5] = 32'h47; cfg_arr[5] = cfgByte(1, 1, 1, 2'd3, 0);
        applyStimulus(32'h40, 2'b00, 2'b00, 1);
        applyStimulus(32'h41, 2'b00, 2'b00, 1);
        waitDrain();

        // Lock bit against M-mode
        clearCfg();
        pa_arr[1] = 32'h80; cfg_arr[1] = cfgByte(0, 1, 1, 2'd2, 1);
        applyStimulus(32'h80, 2'b00, 2'b11, 1);
        waitDrain();
        cfg_arr[1] = cfgByte(0, 1, 1, 2'd2, 0);
        applyStimulus(32'h80, 2'b00, 2'b11, 1);
        applyStimulus(32'h200, 2'b00, 2'b11, 1);
        applyStimulus(32'h200, 2'b00, 2'b10, 1);
        waitDrain();

        // Degenerate TOR ranges and reserved access type
        clearCfg();
        cfg_arr[0] = cfgByte(1, 1, 1, 2'd1, 0);
        pa_arr[6] = 32'h500;
        pa_arr[7] = 32'h300; cfg_arr[7] = cfgByte(1, 1, 1, 2'd1, 0);
        applyStimulus(32'h0, 2'b00, 2'b00, 1);
        applyStimulus(32'h400, 2'b00, 2'b00, 1);
        waitDrain();
        pa_arr[0] = 32'h100;
        applyStimulus(32'h10, 2'b11, 2'b11, 1);
        waitDrain();

        // Held backpressure
        bp_hold = 1;
        applyStimulus(32'h10, 2'b00, 2'b01, 1);
        n = 0;
        while (!resp_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_resp_seen", resp_vld, 1);
        repeat (10) @(negedge clk);
        checkOutput("bp_resp_held", resp_vld, 1);
        bp_hold = 0;
        waitDrain();

        // Reset in the middle of a scan discards the request
        clearCfg();
        applyStimulus(32'h123, 2'b00, 2'b00, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        checkOutput("abort_resp_vld", resp_vld, 0);
        checkOutput("abort_req_rdy_in_rst", req_rdy, 0);
        rst = 0;
        #1;
        checkOutput("abort_req_rdy", req_rdy, 1);
        repeat (20) begin
            @(negedge clk);
            checkOutput("abort_no_resp", resp_vld, 0);
        end

        // Randomized configurations, accesses and backpressure
        bp_rand = 1;
        for (int g = 0; g < 30; g++) begin
            waitDrain();
            for (int i = 0; i < N; i++) begin
                pa_arr[i]  = AW'($urandom_range(0, 511));
                cfg_arr[i] = cfgByte(1'($urandom), 1'($urandom), 1'($urandom),
                                     2'($urandom), ($urandom_range(0, 3) == 0));
            end
            for (int k = 0; k < 10; k++) begin
                applyStimulus(AW'($urandom_range(0, 511)), 2'($urandom), 2'($urandom), 1);
            end
        end
        waitDrain();
        bp_rand = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
